// File: rtl/hp1349a_cmd_seq.sv
// Display command sequencer: pulls 16-bit command words from the bus FIFO,
// decodes plot/graph/text/set-condition and hands vectors or characters downstream.
module hp1349a_cmd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_read_en,
  input  logic [15:0] fifo_read_data,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic [10:0] vec_x,
  output logic [10:0] vec_y,
  output logic        vec_draw,
  output logic        chr_valid,
  input  logic        chr_ready,
  output logic [7:0]  chr_code,
  output logic [3:0]  chr_size,
  output logic        clr_pulse,
  output logic        busy
);

  localparam int unsigned CMD_W   = 15;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned CODE_W  = 8;
  localparam int unsigned SIZE_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_VEC_WAIT,
    ST_CHR_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic [COORD_W-1:0]   pend_x_q, pend_x_d;
  logic [COORD_W-1:0]   graph_x_q, graph_x_d;
  logic [COORD_W-1:0]   graph_step_q, graph_step_d;
  logic [COORD_W-1:0]   vec_x_q, vec_x_d;
  logic [COORD_W-1:0]   vec_y_q, vec_y_d;
  logic                 vec_draw_q, vec_draw_d;
  logic                 vec_valid_q, vec_valid_d;
  logic                 is_graph_q, is_graph_d;
  logic [CODE_W-1:0]    chr_code_q, chr_code_d;
  logic [SIZE_W-1:0]    chr_size_q, chr_size_d;
  logic                 chr_valid_q, chr_valid_d;
  logic                 clr_pulse_q, clr_pulse_d;

  // Bit 15 of the command word carries no meaning for this block.
  logic unused_bit15;
  assign unused_bit15 = fifo_read_data[15];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      pend_x_q     <= '0;
      graph_x_q    <= '0;
      graph_step_q <= COORD_W'(1);
      vec_x_q      <= '0;
      vec_y_q      <= '0;
      vec_draw_q   <= 1'b0;
      vec_valid_q  <= 1'b0;
      is_graph_q   <= 1'b0;
      chr_code_q   <= '0;
      chr_size_q   <= '0;
      chr_valid_q  <= 1'b0;
      clr_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      pend_x_q     <= pend_x_d;
      graph_x_q    <= graph_x_d;
      graph_step_q <= graph_step_d;
      vec_x_q      <= vec_x_d;
      vec_y_q      <= vec_y_d;
      vec_draw_q   <= vec_draw_d;
      vec_valid_q  <= vec_valid_d;
      is_graph_q   <= is_graph_d;
      chr_code_q   <= chr_code_d;
      chr_size_q   <= chr_size_d;
      chr_valid_q  <= chr_valid_d;
      clr_pulse_q  <= clr_pulse_d;
    end
  end

  // Next-state, decode and handshake logic.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    pend_x_d     = pend_x_q;
    graph_x_d    = graph_x_q;
    graph_step_d = graph_step_q;
    vec_x_d      = vec_x_q;
    vec_y_d      = vec_y_q;
    vec_draw_d   = vec_draw_q;
    vec_valid_d  = vec_valid_q;
    is_graph_d   = is_graph_q;
    chr_code_d   = chr_code_q;
    chr_size_d   = chr_size_q;
    chr_valid_d  = chr_valid_q;
    clr_pulse_d  = 1'b0;
    fifo_read_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Read strobe is gated by rst so a reset cycle never pops a word.
        if (!fifo_empty && !rst) begin
          fifo_read_en = 1'b1;
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cmd_d   = fifo_read_data[CMD_W-1:0];
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        case (cmd_q[14:13])
          2'b00: begin
            if (!cmd_q[12]) begin
              pend_x_d = cmd_q[10:0];
            end else begin
              vec_x_d     = pend_x_q;
              vec_y_d     = cmd_q[10:0];
              vec_draw_d  = cmd_q[11];
              vec_valid_d = 1'b1;
              is_graph_d  = 1'b0;
              state_d     = ST_VEC_WAIT;
            end
          end
          2'b01: begin
            vec_x_d     = graph_x_q;
            vec_y_d     = cmd_q[10:0];
            vec_draw_d  = 1'b1;
            vec_valid_d = 1'b1;
            is_graph_d  = 1'b1;
            state_d     = ST_VEC_WAIT;
          end
          2'b10: begin
            chr_code_d  = cmd_q[7:0];
            chr_valid_d = 1'b1;
            state_d     = ST_CHR_WAIT;
          end
          default: begin
            case (cmd_q[12:11])
              2'b00:   graph_step_d = cmd_q[10:0];
              2'b01:   graph_x_d    = '0;
              2'b10:   chr_size_d   = cmd_q[3:0];
              default: clr_pulse_d  = 1'b1;
            endcase
          end
        endcase
      end
      ST_VEC_WAIT: begin
        if (vec_ready) begin
          vec_valid_d = 1'b0;
          state_d     = ST_IDLE;
          // Graph X advances only once the point is accepted; wraps at 11 bits.
          if (is_graph_q) graph_x_d = graph_x_q + graph_step_q;
        end
      end
      ST_CHR_WAIT: begin
        if (chr_ready) begin
          chr_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign vec_valid = vec_valid_q;
  assign vec_x     = vec_x_q;
  assign vec_y     = vec_y_q;
  assign vec_draw  = vec_draw_q;
  assign chr_valid = chr_valid_q;
  assign chr_code  = chr_code_q;
  assign chr_size  = chr_size_q;
  assign clr_pulse = clr_pulse_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hp1349a_cmd_seq.sv
// Scoreboard bench for hp1349a_cmd_seq: a reference model predicts every vector
// and character transfer as words are queued into a behavioural FIFO.
module tb_hp1349a_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_read_en;
  logic [15:0] fifo_read_data = '0;
  logic        vec_valid;
  logic        vec_ready = 1'b1;
  logic [10:0] vec_x;
  logic [10:0] vec_y;
  logic        vec_draw;
  logic        chr_valid;
  logic        chr_ready = 1'b1;
  logic [7:0]  chr_code;
  logic [3:0]  chr_size;
  logic        clr_pulse;
  logic        busy;

  hp1349a_cmd_seq dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_x(vec_x), .vec_y(vec_y), .vec_draw(vec_draw),
    .chr_valid(chr_valid), .chr_ready(chr_ready), .chr_code(chr_code), .chr_size(chr_size),
    .clr_pulse(clr_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int rd_count = 0;
  int clr_cnt  = 0;
  logic [15:0] fifo_q[$];
  logic [31:0] sb_q[$];

  logic [10:0] m_px = '0;
  logic [10:0] m_gx = '0;
  logic [10:0] m_step = 11'd1;
  logic [3:0]  m_sz = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_vec(input logic d, input logic [10:0] x, input logic [10:0] y);
    return 32'({4'h1, d, x, y});
  endfunction

  function automatic logic [31:0] mk_chr(input logic [3:0] s, input logic [7:0] c);
    return 32'({4'h2, 11'h0, s, c});
  endfunction

  // Reference model: word-level semantics, applied in FIFO order.
  task automatic model(input logic [15:0] w);
    case (w[14:13])
      2'b00: if (!w[12]) m_px = w[10:0]; else sb_q.push_back(mk_vec(w[11], m_px, w[10:0]));
      2'b01: begin
        sb_q.push_back(mk_vec(1'b1, m_gx, w[10:0]));
        m_gx = m_gx + m_step;
      end
      2'b10: sb_q.push_back(mk_chr(m_sz, w[7:0]));
      default: case (w[12:11])
        2'b00: m_step = w[10:0];
        2'b01: m_gx = '0;
        2'b10: m_sz = w[3:0];
        default: ;
      endcase
    endcase
  endtask

  task automatic send(input logic [15:0] w);
    @(posedge clk); #2;
    fifo_q.push_back(w);
    model(w);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !busy && sb_q.size() == 0) break;
    end
    if (k == 500) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Behavioural FIFO: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifo_read_en) begin
      rd_count++;
      if (fifo_q.size() == 0) check("read_when_empty", 32'd1, 32'd0);
      else fifo_read_data <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) fifo_empty = (fifo_q.size() == 0);

  // Monitor: handshakes are judged at negedge, completing on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (vec_valid && chr_valid) check("both_valid", 32'd1, 32'd0);
      if (fifo_read_en && busy) check("read_outside_idle", 32'd1, 32'd0);
      if (clr_pulse) begin
        clr_cnt++;
        check("clr_no_valid", 32'(vec_valid | chr_valid), 32'd0);
      end
      if (vec_valid && vec_ready) begin
        if (sb_q.size() == 0) check("vec_unexpected", 32'd1, 32'd0);
        else check("vec_xfer", mk_vec(vec_draw, vec_x, vec_y), sb_q.pop_front());
      end
      if (chr_valid && chr_ready) begin
        if (sb_q.size() == 0) check("chr_unexpected", 32'd1, 32'd0);
        else check("chr_xfer", mk_chr(chr_size, chr_code), sb_q.pop_front());
      end
    end
  end

  initial begin
    int rd0;
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vec_valid", 32'(vec_valid), 32'd0);
    check("rst_chr_valid", 32'(chr_valid), 32'd0);
    check("rst_clr", 32'(clr_pulse), 32'd0);
    check("rst_read_en", 32'(fifo_read_en), 32'd0);
    check("rst_vec_payload", 32'({vec_draw, vec_x, vec_y}), 32'd0);
    check("rst_chr_payload", 32'({chr_size, chr_code}), 32'd0);
    rst = 1'b0;

    // Plot X then Y: one vector, two FIFO reads.
    rd0 = rd_count;
    send(16'h0064);
    send(16'h18C8);
    wait_idle();
    check("plot_reads", 32'(rd_count - rd0), 32'd2);

    // Graph mode with step 5, then graph_x observed at 10; Y-only plot reuses pend_x.
    send(16'h6005);
    send(16'h2010);
    send(16'h2020);
    send(16'h2030);
    send(16'h1005);
    wait_idle();

    // Character stall: payload must hold and no further FIFO reads occur.
    send(16'h7003);
    wait_idle();
    chr_ready = 1'b0;
    send(16'h4041);
    for (k = 0; k < 50 && !chr_valid; k++) @(negedge clk);
    check("chr_valid_rise", 32'(chr_valid), 32'd1);
    send(16'h4042);
    rd0 = rd_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("chr_hold_valid", 32'(chr_valid), 32'd1);
      check("chr_hold_code", 32'(chr_code), 32'h41);
    end
    check("chr_stall_reads", 32'(rd_count - rd0), 32'd0);
    @(posedge clk); #2 chr_ready = 1'b1;
    wait_idle();

    // Graph X wrap at 11 bits: 2045 + 5 = 2.
    send(16'h6800);
    send(16'h67FD);
    send(16'h2001);
    send(16'h6005);
    send(16'h2002);
    send(16'h2003);
    wait_idle();

    // Clear strobe: exactly one cycle.
    clr_cnt = 0;
    send(16'h7800);
    wait_idle();
    check("clr_width", 32'(clr_cnt), 32'd1);

    // Reset during VEC_WAIT discards the pending vector and re-reads nothing.
    vec_ready = 1'b0;
    @(posedge clk); #2 fifo_q.push_back(16'h2004);
    for (k = 0; k < 50 && !vec_valid; k++) @(negedge clk);
    check("vec_wait_reached", 32'(vec_valid), 32'd1);
    rd0 = rd_count;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_hs_vec_valid", 32'(vec_valid), 32'd0);
    check("rst_hs_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_px = '0; m_gx = '0; m_step = 11'd1; m_sz = '0;
    vec_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hs_no_reread", 32'(rd_count - rd0), 32'd0);
    send(16'h2007);
    send(16'hA008);
    wait_idle();
    check("post_rst_reads", 32'(rd_count - rd0), 32'd2);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
